pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-sequencing controller for the 2-bit program counter. Fetches one 4-bit instruction per step, decodes it, and either advances the counter (one-cycle step pulse) or loads a jump target via the counter's set/reset load path (`openpulse`/`enabled`/`jno`). Sits between instruction storage and the program counter, and owns all of the counter's control inputs.

## Interface
- `JCNT_W`, default 4: width of the saturating taken-jump counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `R`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin or resume execution; sampled in IDLE and HALTED only.
- `halt_req`  in  1  request stop at the next instruction boundary; sticky until serviced.
- `instr`  in  4  instruction word: `[3:2]` opcode, `[1:0]` target; valid the cycle after `fetch`.
- `ovf`  in  1  overflow flag; sampled with `instr`.
- `select`  in  2  current program-counter value; used only for `pc_out`.
- `fetch`  out  1  one-cycle instruction read strobe.
- `pc_step`  out  1  one-cycle advance enable to the program counter.
- `openpulse`  out  1  counter load strobe.
- `enabled`  out  1  counter load enable; asserted together with `openpulse`.
- `jno`  out  2  load target; holds the target during a load and is 0 otherwise.
- `busy`  out  1  high in FETCH, DECODE, STEP and LOAD.
- `halted`  out  1  high in HALTED.
- `pc_out`  out  2  registered copy of `select` taken at the DECODE cycle.
- `jump_cnt`  out  JCNT_W  taken jumps since reset; saturates at all-ones.

## Operation
- States: IDLE, FETCH, DECODE, STEP, LOAD, HALTED.
- IDLE: if `start`, go to FETCH; otherwise stay.
- FETCH: `fetch`=1 for one cycle. Always go to DECODE.
- DECODE: latch `instr` and `ovf`, and register `select` into `pc_out`. Opcode handling:
  - 00 NOP: go to STEP.
  - 01 JNO: if `ovf`=0, go to LOAD; if `ovf`=1, go to STEP.
  - 10 JMP: go to LOAD unconditionally.
  - 11 HALT: go to HALTED. The counter is not stepped.
- STEP: `pc_step`=1 for one cycle. Next state is HALTED if the halt flag is set, otherwise FETCH.
- LOAD: `openpulse`=`enabled`=1 and `jno`=latched target for one cycle. `jump_cnt` increments unless it is saturated. Next state is HALTED if the halt flag is set, otherwise FETCH.
- HALTED: `halted`=1. On `start`, go to FETCH and clear the halt flag.
- Halt flag:
  - Set when `halt_req`=1 in any state except IDLE and HALTED.
  - Cleared on leaving HALTED and by `R`.
  - A `halt_req` in the same cycle as the STEP/LOAD exit still takes effect at that exit.
- At most one of `fetch`, `pc_step`, `openpulse` is high in any cycle.

## Timing
- Reset: `R`=1 at an edge forces IDLE on the next cycle, regardless of state (including mid-LOAD). After reset:
  - All strobes are 0 and `jno`=0.
  - `busy`=0, `halted`=0, `pc_out`=0, `jump_cnt`=0, halt flag clear.
- `R` has priority over `start` and `halt_req`.
- Each instruction takes 3 cycles (FETCH, DECODE, STEP/LOAD); HALT takes 2 cycles (FETCH, DECODE) to reach HALTED.
- `start` sampled high in IDLE gives `fetch`=1 in the next cycle.
- `start` is ignored while `busy`=1.
- All outputs are registered; they are decoded from the state register with no combinational path from inputs.
- `jno` is valid only while `openpulse`=1.

## Test plan
- Reset mid-LOAD: assert `R` during LOAD with target 2'b10 -> next cycle IDLE, all outputs 0, `jump_cnt`=0.
- NOP run: `start`, `instr`=4'b0000 three times -> `fetch` at cycles 1, 4, 7 and `pc_step` at cycles 3, 6, 9; `openpulse` never high.
- JNO: `instr`=4'b0110 with `ovf`=0 -> LOAD cycle with `openpulse`=`enabled`=1, `jno`=2'b10, `jump_cnt`=1. Same instruction with `ovf`=1 -> `pc_step` instead, `jump_cnt` unchanged.
- JMP saturation with `JCNT_W`=2: five `instr`=4'b1001 -> `jump_cnt` reads 1, 2, 3, 3, 3; `jno`=2'b01 on each load.
- HALT then resume: `instr`=4'b1100 -> `halted`=1 two cycles after `fetch`, no `pc_step`. Then `start` -> `fetch` next cycle, `halted`=0.
- Halt request: pulse `halt_req` during DECODE of a NOP -> `pc_step` fires, then HALTED; no further `fetch` until `start`.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller driving the 2-bit program counter's step and load paths.
module pc_sequencer #(
  parameter int JCNT_W = 4
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic              halt_req,
  input  logic [3:0]        instr,
  input  logic              ovf,
  input  logic [1:0]        select,
  output logic              fetch,
  output logic              pc_step,
  output logic              openpulse,
  output logic              enabled,
  output logic [1:0]        jno,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        pc_out,
  output logic [JCNT_W-1:0] jump_cnt
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, STEP, LOAD, HALTED} state_e;
  state_e state_q, state_d;
  logic halt_q, halt_d;
  logic take;
  always_comb begin
    take = instr[3:2] == 2'b10 || (instr[3:2] == 2'b01 && !ovf);
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = start ? FETCH : IDLE;
      FETCH:       state_d = DECODE;
      DECODE:      state_d = instr[3:2] == 2'b11 ? HALTED : take ? LOAD : STEP;
      STEP, LOAD:  state_d = (halt_q || halt_req) ? HALTED : FETCH;
      HALTED:      state_d = start ? FETCH : HALTED;
      default:     state_d = IDLE;
    endcase
    if (R) state_d = IDLE;
    halt_d = R ? 1'b0
           : state_q == HALTED ? halt_q && !start
           : halt_q || (halt_req && state_q != IDLE);
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    halt_q    <= halt_d;
    fetch     <= state_d == FETCH;
    pc_step   <= state_d == STEP;
    openpulse <= state_d == LOAD;
    enabled   <= state_d == LOAD;
    jno       <= state_d == LOAD ? instr[1:0] : 2'b00;
    busy      <= state_d inside {FETCH, DECODE, STEP, LOAD};
    halted    <= state_d == HALTED;
    if (R) begin
      pc_out   <= '0;
      jump_cnt <= '0;
    end else begin
      if (state_q == DECODE) pc_out <= select;
      if (state_d == LOAD && !(&jump_cnt)) jump_cnt <= jump_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus random stimulus against an instruction-level model.
module tb_pc_sequencer;
  logic clk = 0, R, start, halt_req, ovf, fetch, pc_step, openpulse, enabled, busy, halted;
  logic [3:0] instr;
  logic [1:0] select, jno, pc_out, jump_cnt;
  int n_vec = 0, n_err = 0;
  int m_mode, m_ph, m_cnt;
  bit m_hflag;
  logic [1:0] m_pc, m_tgt;
  logic [9:0] fv, sv;
  int exp_cnt [5] = '{1, 2, 3, 3, 3};

  pc_sequencer #(.JCNT_W(2)) dut (
    .clk(clk), .R(R), .start(start), .halt_req(halt_req), .instr(instr), .ovf(ovf),
    .select(select), .fetch(fetch), .pc_step(pc_step), .openpulse(openpulse),
    .enabled(enabled), .jno(jno), .busy(busy), .halted(halted), .pc_out(pc_out),
    .jump_cnt(jump_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: mode 0 idle / 1 running / 2 halted; phase 0 fetch, 1 decode, 2 step, 3 load
  task automatic model(input bit r, st, hr, input logic [3:0] ins, input bit ov, input logic [1:0] sel);
    bit hset;
    int op;
    if (r) begin
      m_mode = 0; m_ph = 0; m_hflag = 0; m_cnt = 0; m_pc = 0; m_tgt = 0;
      return;
    end
    hset = hr && m_mode == 1;
    op = int'(ins[3:2]);
    if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_ph = 0; end
    end else if (m_mode == 2) begin
      if (st) begin m_mode = 1; m_ph = 0; m_hflag = 0; end
    end else if (m_ph == 0) m_ph = 1;
    else if (m_ph == 1) begin
      m_pc = sel;
      if (op == 3) m_mode = 2;
      else if (op == 2 || (op == 1 && !ov)) begin
        m_ph = 3; m_tgt = ins[1:0]; m_cnt = m_cnt < 3 ? m_cnt + 1 : 3;
      end else m_ph = 2;
    end else if (m_hflag || hr) m_mode = 2;
    else m_ph = 0;
    if (hset) m_hflag = 1;
  endtask

  function automatic logic [11:0] obs();
    return {fetch, pc_step, openpulse, enabled, jno, busy, halted, pc_out, jump_cnt};
  endfunction

  function automatic logic [11:0] expv();
    bit run = m_mode == 1, ld = run && m_ph == 3;
    return {run && m_ph == 0, run && m_ph == 2, ld, ld, ld ? m_tgt : 2'b00,
            run, m_mode == 2, m_pc, 2'(m_cnt)};
  endfunction

  task automatic step(input bit r, st, hr, input logic [3:0] ins, input bit ov);
    R = r; start = st; halt_req = hr; instr = ins; ovf = ov;
    select = 2'($urandom);
    model(r, st, hr, ins, ov, select);
    @(posedge clk);
    #1;
    chk("outputs", 16'(obs()), 16'(expv()));
    chk("strobe_onehot", 16'($countones({fetch, pc_step, openpulse}) <= 1), 16'd1);
  endtask

  initial begin
    R = 1; start = 0; halt_req = 0; instr = 0; ovf = 0; select = 0;
    @(negedge clk);
    step(1, 0, 0, 4'h0, 0);
    chk("reset_state", 16'(obs()), 16'd0);
    // NOP run: fetch at 1,4,7 and pc_step at 3,6,9
    fv = 0; sv = 0;
    for (int k = 1; k <= 9; k++) begin
      step(0, k == 1, 0, 4'b0000, 0);
      fv[k] = fetch; sv[k] = pc_step;
      chk("nop_no_load", 16'(openpulse), 16'd0);
    end
    chk("nop_fetch_pattern", 16'(fv), 16'h092);
    chk("nop_step_pattern", 16'(sv), 16'h248);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'b0110, 0);
    chk("jno_load", 16'({openpulse, enabled, jno, jump_cnt}), 16'b11_10_01);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'b0110, 1);
    chk("jno_ovf_step", 16'({pc_step, openpulse, jump_cnt}), 16'b10_01);
    // JMP saturation from a fresh reset
    step(1, 0, 0, 4'h0, 0);
    step(0, 1, 0, 4'b1001, 0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step(0, 0, 0, 4'b1001, 0);
      step(0, 0, 0, 4'b1001, 0);
      step(0, 0, 0, 4'b1001, 0);
      chk("jmp_sat_cnt", 16'(jump_cnt), 16'(exp_cnt[j]));
      chk("jmp_sat_jno", 16'({openpulse, jno}), 16'b1_01);
    end
    // reset in the middle of a load
    step(0, 0, 0, 4'b1010, 0);
    step(0, 0, 0, 4'b1010, 0);
    step(0, 0, 0, 4'b1010, 0);
    chk("pre_reset_load", 16'({openpulse, jno}), 16'b1_10);
    step(1, 1, 1, 4'b1010, 0);
    chk("reset_mid_load", 16'(obs()), 16'd0);
    // HALT then resume
    step(0, 1, 0, 4'b1100, 0);
    step(0, 0, 0, 4'b1100, 0);
    step(0, 0, 0, 4'b1100, 0);
    chk("halt_reached", 16'({halted, pc_step, busy}), 16'b100);
    step(0, 1, 0, 4'b0000, 0);
    chk("resume_fetch", 16'({fetch, halted}), 16'b10);
    // halt request during DECODE of a NOP
    step(0, 0, 0, 4'b0000, 0);
    step(0, 0, 1, 4'b0000, 0);
    chk("hreq_step", 16'(pc_step), 16'd1);
    step(0, 0, 0, 4'b0000, 0);
    chk("hreq_halted", 16'(halted), 16'd1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'b0000, 0);
    chk("hreq_no_fetch", 16'({fetch, halted}), 16'b01);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
           4'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
